// File: rtl/axis_cpu_defs.sv
// Shared definitions for the axis_cpu input-side blocks.
//   AXIS_CPU_RR_W(n) : width of a source index for n sources (minimum 1 bit)
//   arb_state_e      : packet arbiter FSM encoding
`ifndef AXIS_CPU_DEFS_SV
`define AXIS_CPU_DEFS_SV
`define AXIS_CPU_RR_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package axis_cpu_defs;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry in-order skid buffer for an AXI-Stream style channel.
// Ports:
//   clk, rst (async, active-low)
//   in_data/in_vld/in_rdy    : upstream side, in_rdy comes straight from a flop
//   out_data/out_vld/out_rdy : downstream side, out_data/out_vld come from flops
// Handshake: a beat transfers on a rising edge where vld and rdy are both high;
// a holder of vld keeps data stable until rdy. out_rdy never reaches in_rdy
// combinationally.
module axis_skid2 #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             rdy_q;
  logic             push, pop;

  assign in_rdy   = rdy_q;
  assign out_vld  = (cnt_q != 2'd0);
  assign out_data = head_q;
  assign push     = in_vld & rdy_q;
  assign pop      = out_vld & out_rdy;

  // head_q is always the oldest beat; tail_q only holds the second one.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = in_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d = in_data;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        // push is impossible here because rdy_q is low when full
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/axis_cpu_din_arbiter.sv
// Round-robin packet arbiter feeding the din stream of an axis_cpu.
// A source keeps the CPU input from grant until its TLAST beat is accepted.
// Ports:
//   clk, rst (async, active-low)
//   src_en                      : per-source enable, only looked at in IDLE
//   s_TDATA/s_TVALID/s_TLAST    : upstream streams, source i at slice i
//   s_TREADY                    : upstream readies, at most one bit high
//   din_TDATA/TLAST/TID/TVALID  : registered output to the CPU
//   din_TREADY                  : from the CPU
//   busy                        : FSM state (1 = LOCKED)
//   grant                       : current or most recent granted source
// Handshake: a beat transfers on a rising edge where TVALID and TREADY are
// both high; TVALID never waits on TREADY and payload is held while stalled.
module axis_cpu_din_arbiter
  import axis_cpu_defs::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = `AXIS_CPU_RR_W(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            src_en,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_TDATA,
  input  logic [N_SRC-1:0]            s_TVALID,
  input  logic [N_SRC-1:0]            s_TLAST,
  output logic [N_SRC-1:0]            s_TREADY,
  output logic [DATA_WIDTH-1:0]       din_TDATA,
  output logic                        din_TLAST,
  output logic [ID_WIDTH-1:0]         din_TID,
  output logic                        din_TVALID,
  input  logic                        din_TREADY,
  output logic                        busy,
  output logic [ID_WIDTH-1:0]         grant
);

  localparam int SKW = DATA_WIDTH + 1 + ID_WIDTH;

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [N_SRC-1:0]      req;
  logic                  cur_valid, cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  skid_in_vld, skid_in_rdy;
  logic [SKW-1:0]        skid_in_data, skid_out_data;

  // Rotate so the bit after 'last' sits at position 0, take the lowest set
  // bit, then rotate the index back.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [N_SRC-1:0]    rq,
                                                  input logic [ID_WIDTH-1:0] last);
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    int                 start;
    int                 idx;
    start = (int'(last) + 1) % N_SRC;
    dbl   = {rq, rq};
    rot   = N_SRC'(dbl >> start);
    idx   = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) idx = i;
    end
    return ID_WIDTH'((start + idx) % N_SRC);
  endfunction

  assign req = s_TVALID & src_en;

  // Mux the granted source onto the skid input.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        cur_valid = s_TVALID[i];
        cur_last  = s_TLAST[i];
        cur_data  = s_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_TREADY     = '0;
    skid_in_vld  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d      = rr_pick(req, last_grant_q);
          last_grant_d = grant_d;
          state_d      = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        // src_en is ignored here so a started packet always completes
        for (int i = 0; i < N_SRC; i++) begin
          s_TREADY[i] = (grant_q == ID_WIDTH'(i)) && skid_in_rdy;
        end
        skid_in_vld = cur_valid;
        if (cur_valid && skid_in_rdy && cur_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(N_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign skid_in_data = {cur_last, grant_q, cur_data};

  axis_skid2 #(
    .WIDTH(SKW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_data (skid_in_data),
    .in_vld  (skid_in_vld),
    .in_rdy  (skid_in_rdy),
    .out_data(skid_out_data),
    .out_vld (din_TVALID),
    .out_rdy (din_TREADY)
  );

  assign din_TLAST = skid_out_data[SKW-1];
  assign din_TID   = skid_out_data[DATA_WIDTH +: ID_WIDTH];
  assign din_TDATA = skid_out_data[DATA_WIDTH-1:0];
  assign busy      = (state_q == ARB_LOCKED);
  assign grant     = grant_q;

endmodule

// File: tb/tb_axis_cpu_din_arbiter.sv
module tb_axis_cpu_din_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    src_en;
  logic [N*DW-1:0] s_TDATA;
  logic [N-1:0]    s_TVALID;
  logic [N-1:0]    s_TLAST;
  logic [N-1:0]    s_TREADY;
  logic [DW-1:0]   din_TDATA;
  logic            din_TLAST;
  logic [IW-1:0]   din_TID;
  logic            din_TVALID;
  logic            din_TREADY;
  logic            busy;
  logic [IW-1:0]   grant;

  axis_cpu_din_arbiter #(
    .N_SRC(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .src_en(src_en),
    .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TLAST(s_TLAST), .s_TREADY(s_TREADY),
    .din_TDATA(din_TDATA), .din_TLAST(din_TLAST), .din_TID(din_TID),
    .din_TVALID(din_TVALID), .din_TREADY(din_TREADY),
    .busy(busy), .grant(grant)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [DW+IW:0] exp_q[$];
  logic [IW-1:0]  out_id[$];
  logic [IW-1:0]  pkt_log[$];
  int             out_cyc[$];
  logic           out_last[$];
  int             pkts_done;
  logic           in_pkt;
  logic           stall_q;
  logic [DW+IW:0] stall_data;
  logic           rnd_rdy;

  // source models
  logic [N-1:0]  src_act;
  int            src_len[N];
  int            src_beat[N];
  int            src_pkt[N];
  int            src_rem[N];
  logic [DW-1:0] src_base[N];
  int            in_cnt[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      s_TVALID[i] = src_act[i] && (src_rem[i] > 0);
      s_TDATA[i*DW +: DW] = src_base[i] + DW'(src_pkt[i] << 8) + DW'(src_beat[i]);
      s_TLAST[i] = (src_beat[i] == src_len[i] - 1);
    end
  endtask

  task automatic clr_srcs();
    for (int i = 0; i < N; i++) begin
      src_len[i]  = 3;
      src_beat[i] = 0;
      src_pkt[i]  = 0;
      src_rem[i]  = 1000;
      src_base[i] = DW'(i) << 24;
      in_cnt[i]   = 0;
    end
    src_act = '0;
    src_en  = '1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    out_id.delete();
    pkt_log.delete();
    out_cyc.delete();
    out_last.delete();
    pkts_done = 0;
    in_pkt    = 1'b0;
    stall_q   = 1'b0;
  endtask

  // One clock: monitor at the falling edge, advance sources after the rising edge.
  task automatic tick();
    logic [N-1:0]   hs;
    logic [DW+IW:0] got;
    @(negedge clk);
    got = {din_TLAST, din_TID, din_TDATA};
    if (stall_q) begin
      chk("hold_valid", 64'(din_TVALID), 64'd1);
      chk("hold_payload", 64'(got), 64'(stall_data));
    end
    chk("tready_onehot",
        64'((s_TREADY == '0) || (busy && s_TREADY == (4'b0001 << grant))), 64'd1);
    hs = s_TVALID & s_TREADY;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        exp_q.push_back({s_TLAST[i], IW'(i), s_TDATA[i*DW +: DW]});
        in_cnt[i]++;
      end
    end
    if (din_TVALID && din_TREADY) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("beat", 64'(got), 64'(exp_q.pop_front()));
      out_id.push_back(din_TID);
      out_cyc.push_back(cyc);
      out_last.push_back(din_TLAST);
      if (!in_pkt) pkt_log.push_back(din_TID);
      in_pkt = !din_TLAST;
      if (din_TLAST) pkts_done++;
    end
    stall_q    = din_TVALID && !din_TREADY;
    stall_data = got;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_pkt[i]++;
          src_rem[i]--;
        end else begin
          src_beat[i]++;
        end
      end
    end
    if (rnd_rdy) din_TREADY = 1'($urandom_range(0, 1));
    drive_srcs();
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    din_TREADY = 1'b1;
    rnd_rdy    = 1'b0;
    clr_srcs();
    drive_srcs();
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tready", 64'(s_TREADY), 64'd0);
    chk("rst_din_valid", 64'(din_TVALID), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_din_payload", 64'({din_TLAST, din_TID, din_TDATA}), 64'd0);
    rst = 1'b1;
  endtask

  task automatic run_until_pkts(input int n_pkts, input int budget, input string nm);
    int n;
    n = 0;
    while (pkts_done < n_pkts && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 64'(pkts_done >= n_pkts), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  vld;
    logic [3:0]  len;
    logic        rnd;
    logic [15:0] exp_ids;   // packet k granted to exp_ids[2k +: 2]
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] a;
    logic [15:0] ids;
    int          nb;

    vecs[0] = '{en: 4'hF, vld: 4'hF, len: 4'd3, rnd: 1'b0, exp_ids: 16'hE4E4};
    vecs[1] = '{en: 4'h5, vld: 4'hF, len: 4'd2, rnd: 1'b0, exp_ids: 16'h8888};
    vecs[2] = '{en: 4'hF, vld: 4'hA, len: 4'd1, rnd: 1'b0, exp_ids: 16'hDDDD};
    vecs[3] = '{en: 4'hE, vld: 4'h7, len: 4'd4, rnd: 1'b0, exp_ids: 16'h9999};
    vecs[4] = '{en: 4'h8, vld: 4'hF, len: 4'd2, rnd: 1'b0, exp_ids: 16'hFFFF};
    vecs[5] = '{en: 4'hF, vld: 4'hF, len: 4'd3, rnd: 1'b1, exp_ids: 16'hE4E4};

    rst = 1'b0; din_TREADY = 1'b1; rnd_rdy = 1'b0;
    clr_srcs(); drive_srcs(); clear_logs();

    // ---- table-driven arbitration order and bubble spacing ----
    for (int v = 0; v < 6; v++) begin
      do_reset();
      src_en  = vecs[v].en;
      src_act = vecs[v].vld;
      for (int i = 0; i < N; i++) src_len[i] = int'(vecs[v].len);
      rnd_rdy = vecs[v].rnd;
      drive_srcs();
      run_until_pkts(8, 400, $sformatf("vec%0d_done", v));
      rnd_rdy = 1'b0;
      din_TREADY = 1'b1;
      ids = vecs[v].exp_ids;
      for (int k = 0; k < 8; k++) begin
        a = (k < pkt_log.size()) ? 64'(pkt_log[k]) : 64'hFFFF;
        chk($sformatf("vec%0d_pkt%0d_id", v, k), a, 64'(ids[2*k +: 2]));
      end
      if (!vecs[v].rnd) begin
        nb = 8 * int'(vecs[v].len);
        if (nb > out_cyc.size()) nb = out_cyc.size();
        for (int j = 1; j < nb; j++)
          chk($sformatf("vec%0d_gap%0d", v, j), 64'(out_cyc[j] - out_cyc[j-1]),
              out_last[j-1] ? 64'd2 : 64'd1);
      end
    end

    // ---- source 2 alone, 0xA/0xB/0xC, latency check ----
    do_reset();
    src_act[2] = 1'b1; src_rem[2] = 1; src_base[2] = 32'hA;
    drive_srcs();
    chk("a_busy_T", 64'(busy), 64'd0);
    tick();
    chk("a_busy_T1", 64'(busy), 64'd1);
    chk("a_grant_T1", 64'(grant), 64'd2);
    chk("a_tready_T1", 64'(s_TREADY), 64'h4);
    chk("a_dvalid_T1", 64'(din_TVALID), 64'd0);
    tick();
    chk("a_beat0", 64'({din_TVALID, din_TLAST, din_TID, din_TDATA}), {29'd0, 1'b1, 1'b0, 2'd2, 32'hA});
    tick();
    chk("a_beat1", 64'({din_TVALID, din_TLAST, din_TID, din_TDATA}), {29'd0, 1'b1, 1'b0, 2'd2, 32'hB});
    tick();
    chk("a_beat2", 64'({din_TVALID, din_TLAST, din_TID, din_TDATA}), {29'd0, 1'b1, 1'b1, 2'd2, 32'hC});
    chk("a_idle_after_last", 64'(busy), 64'd0);
    tick();
    chk("a_drained", 64'(din_TVALID), 64'd0);

    // ---- source 0 arrives while source 1 is mid-packet ----
    do_reset();
    src_act[1] = 1'b1; src_len[1] = 4; src_rem[1] = 1;
    drive_srcs();
    repeat (3) tick();
    src_act[0] = 1'b1; src_len[0] = 2; src_rem[0] = 1;
    drive_srcs();
    run_until_pkts(2, 60, "b_done");
    for (int k = 0; k < 6; k++) begin
      a = (k < out_id.size()) ? 64'(out_id[k]) : 64'hFFFF;
      chk($sformatf("b_id%0d", k), a, (k < 4) ? 64'd1 : 64'd0);
    end

    // ---- backpressure: din_TREADY low for 5 cycles in a 6-beat packet ----
    do_reset();
    src_act[0] = 1'b1; src_len[0] = 6; src_rem[0] = 1;
    drive_srcs();
    tick();
    din_TREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("c_tready%0d", k), 64'(s_TREADY[0]), (k < 2) ? 64'd1 : 64'd0);
      tick();
    end
    chk("c_buffered", 64'(in_cnt[0]), 64'd2);
    din_TREADY = 1'b1;
    run_until_pkts(1, 40, "c_done");
    chk("c_beats_out", 64'(out_id.size()), 64'd6);
    chk("c_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---- enable cleared mid-packet ----
    do_reset();
    src_en = 4'b0101; src_act = 4'hF;
    drive_srcs();
    begin
      int n;
      n = 0;
      while (in_cnt[0] == 0 && n < 20) begin tick(); n++; end
    end
    chk("d_src0_started", 64'(in_cnt[0] > 0), 64'd1);
    src_en[0] = 1'b0;
    run_until_pkts(4, 100, "d_done");
    for (int k = 0; k < 4; k++) begin
      a = (k < pkt_log.size()) ? 64'(pkt_log[k]) : 64'hFFFF;
      chk($sformatf("d_pkt%0d_id", k), a, (k == 0) ? 64'd0 : 64'd2);
    end

    // ---- asynchronous reset in the middle of a packet ----
    do_reset();
    src_act[0] = 1'b1; src_len[0] = 4; src_rem[0] = 1;
    drive_srcs();
    begin
      int n;
      n = 0;
      while (in_cnt[0] < 2 && n < 20) begin tick(); n++; end
    end
    chk("e_mid_packet", 64'({busy, din_TVALID}), 64'b11);
    #2;
    rst = 1'b0;
    #1;
    chk("e_async_valid", 64'(din_TVALID), 64'd0);
    chk("e_async_tready", 64'(s_TREADY), 64'd0);
    chk("e_async_busy", 64'(busy), 64'd0);
    chk("e_async_payload", 64'({din_TLAST, din_TID, din_TDATA}), 64'd0);
    clr_srcs();
    clear_logs();
    src_act = 4'b0011; src_len[0] = 4; src_len[1] = 4; src_rem[0] = 1; src_rem[1] = 1;
    drive_srcs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("e_first_busy", 64'(busy), 64'd1);
    chk("e_first_grant", 64'(grant), 64'd0);
    run_until_pkts(2, 60, "e_done");
    for (int k = 0; k < 2; k++) begin
      a = (k < pkt_log.size()) ? 64'(pkt_log[k]) : 64'hFFFF;
      chk($sformatf("e_pkt%0d_id", k), a, 64'(k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
